// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: special digit codes,
// the dark segment pattern and the scan slot encoding.
package seg_pkg;

  localparam logic [4:0] SEG_MINUS = 5'd10;
  localparam logic [4:0] SEG_E     = 5'd11;
  localparam logic [4:0] SEG_R     = 5'd12;
  localparam logic [4:0] SEG_P     = 5'd13;
  localparam logic [4:0] SEG_A     = 5'd14;
  localparam logic [4:0] SEG_S     = 5'd15;
  localparam logic [4:0] SEG_BLANK = 5'd31;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    SLOT_D1 = 2'd0,
    SLOT_D2 = 2'd1,
    SLOT_D3 = 2'd2,
    SLOT_D4 = 2'd3
  } slot_e;

endpackage

// File: rtl/seg_decoder.sv
// Combinational 5-bit digit code to active-low segment pattern
// (bit 0 = segment a ... bit 6 = segment g); codes 16-31 are dark.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      5'd0:      pattern = 7'b1000000;
      5'd1:      pattern = 7'b1111001;
      5'd2:      pattern = 7'b0100100;
      5'd3:      pattern = 7'b0110000;
      5'd4:      pattern = 7'b0011001;
      5'd5:      pattern = 7'b0010010;
      5'd6:      pattern = 7'b0000010;
      5'd7:      pattern = 7'b1111000;
      5'd8:      pattern = 7'b0000000;
      5'd9:      pattern = 7'b0010000;
      SEG_MINUS: pattern = 7'b0111111;
      SEG_E:     pattern = 7'b0000110;
      SEG_R:     pattern = 7'b0101111;
      SEG_P:     pattern = 7'b0001100;
      SEG_A:     pattern = 7'b0001000;
      SEG_S:     pattern = 7'b0010010;
      default:   pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: latches digit codes on load and
// multiplexes them with registered outputs. Optional blink via SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] d1,
  input  logic [4:0] d2,
  input  logic [4:0] d3,
  input  logic [4:0] d4,
  input  logic       lzb,
`ifdef SEG_BLINK_EN
  input  logic       blink,
`endif
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  slot_e            idx;
  logic [4:0]       q1, q2, q3, q4;
  logic             q_lzb;
  logic             blank1, blank2, blank3;
  logic [4:0]       code;
  logic [6:0]       pattern;
  logic             lit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= SLOT_D1;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt <= '0;
      idx <= slot_e'(idx + 2'd1);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1    <= SEG_BLANK;
      q2    <= SEG_BLANK;
      q3    <= SEG_BLANK;
      q4    <= SEG_BLANK;
      q_lzb <= 1'b0;
    end else if (load) begin
      q1    <= d1;
      q2    <= d2;
      q3    <= d3;
      q4    <= d4;
      q_lzb <= lzb;
    end
  end

  // A zero is only "leading" while every digit to its left was also blanked.
  assign blank1 = q_lzb && (q1 == 5'd0);
  assign blank2 = blank1 && (q2 == 5'd0);
  assign blank3 = blank2 && (q3 == 5'd0);

  always_comb begin
    code = SEG_BLANK;
    case (idx)
      SLOT_D1: code = blank1 ? SEG_BLANK : q1;
      SLOT_D2: code = blank2 ? SEG_BLANK : q2;
      SLOT_D3: code = blank3 ? SEG_BLANK : q3;
      SLOT_D4: code = q4;
      default: code = SEG_BLANK;
    endcase
  end

  seg_decoder u_decoder (
    .code    (code),
    .pattern (pattern)
  );

`ifdef SEG_BLINK_EN
  localparam int BDIV   = (CLK_HZ / (2 * BLINK_HZ) > 0) ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int BCNT_W = (BDIV > 1) ? $clog2(BDIV) : 1;

  logic [BCNT_W-1:0] bcnt;
  logic              phase;

  // Phase starts high so a blink request after reset begins with a lit window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BCNT_W'(BDIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign lit = !(blink && !phase);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= 4'hF;
      seg <= SEG_OFF;
    end else begin
      an  <= lit ? ~(4'b1000 >> idx) : 4'hF;
      seg <= pattern;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with DIV=4: directed glyph/blanking
// checks plus randomized loads and resets against an edge-counting model.
module tb_seg_scan_driver;

  localparam int CLK_HZ   = 8;
  localparam int SCAN_HZ  = 2;
  localparam int BLINK_HZ = 1;
  localparam int DIV      = CLK_HZ / SCAN_HZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       lzb = 1'b0;
  logic [4:0] d1 = 5'd31, d2 = 5'd31, d3 = 5'd31, d4 = 5'd31;
  logic [3:0] an;
  logic [6:0] seg;
`ifdef SEG_BLINK_EN
  logic       blink = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .lzb   (lzb),
`ifdef SEG_BLINK_EN
    .blink (blink),
`endif
    .an    (an),
    .seg   (seg)
  );

  // Reference model: digits displayed by slot derived from the count of
  // clock edges since reset release, glyphs from a lookup table.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0000110,
    7'b0101111, 7'b0001100, 7'b0001000, 7'b0010010
  };

  int unsigned edges = 0;
  logic [4:0]  mq [4] = '{5'd31, 5'd31, 5'd31, 5'd31};
  logic        mlzb = 1'b0;
  logic [3:0]  expAn = 4'hF;
  logic [6:0]  expSeg = 7'h7F;
  bit          modelReady = 1'b0;

  function automatic logic [6:0] modelPattern(int slot);
    bit prevBlank = 1'b1;
    bit blanked = 1'b0;
    for (int i = 0; i <= slot; i++) begin
      blanked = mlzb && (mq[i] == 5'd0) && prevBlank && (i < 3);
      prevBlank = blanked;
    end
    if (blanked || mq[slot] >= 5'd16) return 7'h7F;
    return glyph[mq[slot][3:0]];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      edges = 0;
      for (int i = 0; i < 4; i++) mq[i] = 5'd31;
      mlzb = 1'b0;
      expAn = 4'hF;
      expSeg = 7'h7F;
      modelReady = 1'b1;
    end else begin
      int slot;
      slot = int'((edges / DIV) % 4);
      expAn = 4'hF;
      expAn[3 - slot] = 1'b0;
      expSeg = modelPattern(slot);
      if (load) begin
        mq[0] = d1; mq[1] = d2; mq[2] = d3; mq[3] = d4;
        mlzb = lzb;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      total++;
      if (an !== expAn || seg !== expSeg) begin
        bad++;
        $display("[TB] FAIL model_cmp t=%0t: an=%b seg=%b required an=%b seg=%b",
                 $time, an, seg, expAn, expSeg);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit ld, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] c, input logic [4:0] e, input bit lz);
    load = ld;
    d1 = a; d2 = b; d3 = c; d4 = e;
    lzb = lz;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] wantAn, input logic [6:0] wantSeg);
    total++;
    if (an !== wantAn || seg !== wantSeg) begin
      bad++;
      $display("[TB] FAIL %s: an=%b seg=%b required an=%b seg=%b", name, an, seg, wantAn, wantSeg);
    end
  endtask

  function automatic logic [4:0] randCode();
    if ($urandom_range(0, 3) == 0) return 5'd0;
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic idleRandom();
    applyStimulus(1'b0, randCode(), randCode(), randCode(), randCode(), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    applyStimulus(1'b0, 5'd31, 5'd31, 5'd31, 5'd31, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_hold", 4'hF, 7'h7F);

    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd7, 5'd0, 5'd8, 1'b0);
    tick();
    checkOutput("first_anode", 4'b0111, 7'h7F);
    idleRandom();
    tick();
    checkOutput("digit_1", 4'b0111, 7'b1111001);
    repeat (3) tick();
    checkOutput("digit_7", 4'b1011, 7'b1111000);
    repeat (4) tick();
    checkOutput("digit_0", 4'b1101, 7'b1000000);
    repeat (4) tick();
    checkOutput("digit_8", 4'b1110, 7'b0000000);
    repeat (4) tick();
    checkOutput("wrap_digit_1", 4'b0111, 7'b1111001);

    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    idleRandom();
    repeat (3) tick();
    checkOutput("lzb_slot1", 4'b1011, 7'h7F);
    repeat (4) tick();
    checkOutput("lzb_slot2", 4'b1101, 7'h7F);
    repeat (4) tick();
    checkOutput("lzb_digit_3", 4'b1110, 7'b0110000);

    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    idleRandom();
    tick();
    checkOutput("all_zero_ones", 4'b1110, 7'b1000000);
    repeat (2) tick();
    checkOutput("all_zero_slot0", 4'b0111, 7'h7F);
    repeat (9) tick();
    checkOutput("mid_slot2_blank", 4'b1101, 7'h7F);

    applyStimulus(1'b1, 5'd13, 5'd14, 5'd15, 5'd15, 1'b0);
    tick();
    idleRandom();
    tick();
    checkOutput("pass_s_same_slot", 4'b1101, 7'b0010010);
    repeat (5) tick();
    checkOutput("pass_p_slot0", 4'b0111, 7'b0001100);

    rst_n = 1'b0;
    tick();
    checkOutput("midscan_reset", 4'hF, 7'h7F);
    rst_n = 1'b1;
    tick();
    checkOutput("after_release", 4'b0111, 7'h7F);

    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(($urandom_range(0, 5) == 0), randCode(), randCode(), randCode(), randCode(),
                    1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
